// File: rtl/reg_rename_file.sv
`default_nettype none
// ============================================================================
// Module      : reg_rename_file
// Description : Architectural register file with per-register rename tags,
//               same-group bypass, commit forwarding and misprediction flush.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_rename_file #(
    parameter int XLEN     = 32,
    parameter int ROB_LOG  = 4,
    parameter int ISSUE_W  = 2,
    parameter int COMMIT_W = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            rdy,
    input  logic [2*ISSUE_W-1:0]            src_valid,
    input  logic [2*ISSUE_W*5-1:0]          src_idx,
    output logic [2*ISSUE_W*XLEN-1:0]       src_V,
    output logic [2*ISSUE_W-1:0]            src_R,
    output logic [2*ISSUE_W*ROB_LOG-1:0]    src_Q,
    input  logic [ISSUE_W-1:0]              rename_valid,
    input  logic [ISSUE_W*5-1:0]            issue_rd,
    input  logic [ISSUE_W*ROB_LOG-1:0]      issue_RobId,
    input  logic [COMMIT_W-1:0]             commit_valid,
    input  logic [COMMIT_W*5-1:0]           commit_dest,
    input  logic [COMMIT_W*XLEN-1:0]        commit_value,
    input  logic [COMMIT_W*ROB_LOG-1:0]     commit_RobId,
    input  logic                            jump_flag
);

    localparam int c_NSRC = 2 * ISSUE_W;

    logic [XLEN-1:0]    r_value      [32];
    logic [ROB_LOG-1:0] r_tag        [32];
    logic [XLEN-1:0]    w_value_next [32];
    logic [ROB_LOG-1:0] w_tag_next   [32];
    logic [31:0]        w_rename_hit;

    always_comb begin
        w_rename_hit = '0;
        for (int s = 0; s < ISSUE_W; s++) begin
            if (rename_valid[s]) begin
                w_rename_hit[issue_rd[s*5 +: 5]] = 1'b1;
            end
        end
    end

    // Ascending slot loops let the higher (younger) slot win on collisions.
    always_comb begin
        for (int r = 0; r < 32; r++) begin
            w_value_next[r] = r_value[r];
            w_tag_next[r]   = r_tag[r];
        end
        for (int k = 0; k < COMMIT_W; k++) begin
            if (commit_valid[k] && commit_dest[k*5 +: 5] != 5'd0) begin
                w_value_next[commit_dest[k*5 +: 5]] = commit_value[k*XLEN +: XLEN];
            end
        end
        if (jump_flag) begin
            for (int r = 0; r < 32; r++) begin
                w_tag_next[r] = '0;
            end
        end else begin
            for (int k = 0; k < COMMIT_W; k++) begin
                if (commit_valid[k] && commit_dest[k*5 +: 5] != 5'd0 &&
                    r_tag[commit_dest[k*5 +: 5]] == commit_RobId[k*ROB_LOG +: ROB_LOG] &&
                    !w_rename_hit[commit_dest[k*5 +: 5]]) begin
                    w_tag_next[commit_dest[k*5 +: 5]] = '0;
                end
            end
            for (int s = 0; s < ISSUE_W; s++) begin
                if (rename_valid[s] && issue_rd[s*5 +: 5] != 5'd0) begin
                    w_tag_next[issue_rd[s*5 +: 5]] = issue_RobId[s*ROB_LOG +: ROB_LOG];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 32; r++) begin
                r_value[r] <= '0;
                r_tag[r]   <= '0;
            end
        end else if (rdy) begin
            for (int r = 0; r < 32; r++) begin
                r_value[r] <= w_value_next[r];
                r_tag[r]   <= w_tag_next[r];
            end
        end
    end

    generate
        for (genvar i = 0; i < c_NSRC; i++) begin : g_src
            localparam int c_SLOT = i / 2;

            logic [4:0]         w_idx;
            logic [ROB_LOG-1:0] w_tag;
            logic               w_byp;
            logic [ROB_LOG-1:0] w_byp_q;
            logic               w_fwd;
            logic [XLEN-1:0]    w_fwd_v;
            logic [XLEN-1:0]    w_v;
            logic               w_r;
            logic [ROB_LOG-1:0] w_q;

            assign w_idx = src_idx[i*5 +: 5];
            assign w_tag = r_tag[w_idx];

            always_comb begin
                w_byp   = 1'b0;
                w_byp_q = '0;
                for (int t = 0; t < ISSUE_W; t++) begin
                    if (t < c_SLOT && rename_valid[t] && w_idx != 5'd0 &&
                        issue_rd[t*5 +: 5] == w_idx) begin
                        w_byp   = 1'b1;
                        w_byp_q = issue_RobId[t*ROB_LOG +: ROB_LOG];
                    end
                end
                w_fwd   = 1'b0;
                w_fwd_v = '0;
                for (int k = 0; k < COMMIT_W; k++) begin
                    if (commit_valid[k] && commit_RobId[k*ROB_LOG +: ROB_LOG] == w_tag) begin
                        w_fwd   = 1'b1;
                        w_fwd_v = commit_value[k*XLEN +: XLEN];
                    end
                end
            end

            always_comb begin
                w_v = '0;
                w_r = 1'b0;
                w_q = '0;
                if (src_valid[i]) begin
                    if (w_byp) begin
                        w_q = w_byp_q;
                    end else if (w_tag == '0) begin
                        w_v = r_value[w_idx];
                        w_r = 1'b1;
                    end else if (w_fwd) begin
                        w_v = w_fwd_v;
                        w_r = 1'b1;
                    end else begin
                        w_q = w_tag;
                    end
                end
            end

            assign src_V[i*XLEN +: XLEN]       = w_v;
            assign src_R[i]                    = w_r;
            assign src_Q[i*ROB_LOG +: ROB_LOG] = w_q;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_reg_rename_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_rename_file
// Description : Directed self-checking bench for reg_rename_file.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_rename_file;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic [3:0]  src_valid;
    logic [19:0] src_idx;
    logic [127:0] src_V;
    logic [3:0]  src_R;
    logic [15:0] src_Q;
    logic [1:0]  rename_valid;
    logic [9:0]  issue_rd;
    logic [7:0]  issue_RobId;
    logic [1:0]  commit_valid;
    logic [9:0]  commit_dest;
    logic [63:0] commit_value;
    logic [7:0]  commit_RobId;
    logic        jump_flag;

    int n_checks;
    int n_pass;

    reg_rename_file #(.XLEN(32), .ROB_LOG(4), .ISSUE_W(2), .COMMIT_W(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .src_valid    (src_valid),
        .src_idx      (src_idx),
        .src_V        (src_V),
        .src_R        (src_R),
        .src_Q        (src_Q),
        .rename_valid (rename_valid),
        .issue_rd     (issue_rd),
        .issue_RobId  (issue_RobId),
        .commit_valid (commit_valid),
        .commit_dest  (commit_dest),
        .commit_value (commit_value),
        .commit_RobId (commit_RobId),
        .jump_flag    (jump_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_src(input string tag, input int i, input logic r,
                              input logic [3:0] q, input logic [31:0] v);
        check({tag, ".R"}, 64'(src_R[i]), 64'(r));
        check({tag, ".Q"}, 64'(src_Q[i*4 +: 4]), 64'(q));
        check({tag, ".V"}, 64'(src_V[i*32 +: 32]), 64'(v));
    endtask

    task automatic idle();
        rst = 1'b0; rdy = 1'b1; jump_flag = 1'b0;
        src_valid = '0; src_idx = '0;
        rename_valid = '0; issue_rd = '0; issue_RobId = '0;
        commit_valid = '0; commit_dest = '0; commit_value = '0; commit_RobId = '0;
    endtask

    task automatic rd(input int i, input logic [4:0] idx);
        src_valid[i] = 1'b1;
        src_idx[i*5 +: 5] = idx;
    endtask

    task automatic ren(input int s, input logic [4:0] rdi, input logic [3:0] id);
        rename_valid[s] = 1'b1;
        issue_rd[s*5 +: 5] = rdi;
        issue_RobId[s*4 +: 4] = id;
    endtask

    task automatic cmt(input int k, input logic [4:0] dest, input logic [31:0] val,
                       input logic [3:0] id);
        commit_valid[k] = 1'b1;
        commit_dest[k*5 +: 5] = dest;
        commit_value[k*32 +: 32] = val;
        commit_RobId[k*4 +: 4] = id;
    endtask

    // Advance one edge, then clear all stimulus.
    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        idle();
        rst = 1'b1;
        @(posedge clk);
        tick();

        // Reset state
        rd(0, 5'd5); rd(1, 5'd31); #1;
        expect_src("rst_x5", 0, 1'b1, 4'd0, 32'd0);
        expect_src("rst_x31", 1, 1'b1, 4'd0, 32'd0);
        expect_src("invalid_src", 2, 1'b0, 4'd0, 32'd0);

        // Rename, pending read, commit forward, then stored value
        ren(0, 5'd5, 4'd3); tick();
        rd(0, 5'd5); src_idx[5 +: 5] = 5'd5; #1;
        expect_src("pend_x5", 0, 1'b0, 4'd3, 32'd0);
        expect_src("pend_invalid", 1, 1'b0, 4'd0, 32'd0);
        cmt(0, 5'd5, 32'hDEAD, 4'd3); #1;
        expect_src("fwd_x5", 0, 1'b1, 4'd0, 32'hDEAD);
        tick();
        rd(0, 5'd5); #1;
        expect_src("stored_x5", 0, 1'b1, 4'd0, 32'hDEAD);

        // Intra-group bypass
        ren(0, 5'd7, 4'd4); rd(2, 5'd7); rd(0, 5'd7); #1;
        expect_src("byp_slot1", 2, 1'b0, 4'd4, 32'd0);
        expect_src("byp_slot0_old", 0, 1'b1, 4'd0, 32'd0);
        tick();
        rd(0, 5'd7); #1;
        expect_src("x7_tagged", 0, 1'b0, 4'd4, 32'd0);

        // Rename beats commit-clear, value still written
        ren(0, 5'd9, 4'd2); tick();
        cmt(0, 5'd9, 32'h11, 4'd2); ren(1, 5'd9, 4'd5); tick();
        rd(0, 5'd9); #1;
        expect_src("x9_retag", 0, 1'b0, 4'd5, 32'd0);
        jump_flag = 1'b1; tick();
        rd(0, 5'd9); rd(1, 5'd7); #1;
        expect_src("x9_val", 0, 1'b1, 4'd0, 32'h11);
        expect_src("x7_flushed", 1, 1'b1, 4'd0, 32'd0);

        // Two commits to one dest: higher slot wins
        cmt(0, 5'd10, 32'hA, 4'd0); cmt(1, 5'd10, 32'hB, 4'd0); tick();
        rd(0, 5'd10); #1;
        expect_src("x10_dual", 0, 1'b1, 4'd0, 32'hB);

        // Flush with commit
        ren(0, 5'd1, 4'd6); ren(1, 5'd2, 4'd7); tick();
        ren(0, 5'd3, 4'd8); tick();
        rd(0, 5'd2); rd(1, 5'd3); #1;
        expect_src("x2_pend", 0, 1'b0, 4'd7, 32'd0);
        expect_src("x3_pend", 1, 1'b0, 4'd8, 32'd0);
        jump_flag = 1'b1; cmt(0, 5'd2, 32'h22, 4'd7); ren(1, 5'd4, 4'd9); tick();
        rd(0, 5'd1); rd(1, 5'd2); rd(2, 5'd3); rd(3, 5'd4); #1;
        expect_src("fl_x1", 0, 1'b1, 4'd0, 32'd0);
        expect_src("fl_x2", 1, 1'b1, 4'd0, 32'h22);
        expect_src("fl_x3", 2, 1'b1, 4'd0, 32'd0);
        expect_src("fl_x4", 3, 1'b1, 4'd0, 32'd0);

        // Same-rd renames, mismatched-tag commit, slot-1 forward
        ren(0, 5'd6, 4'd1); ren(1, 5'd6, 4'd2); tick();
        rd(0, 5'd6); #1;
        expect_src("x6_hi_slot", 0, 1'b0, 4'd2, 32'd0);
        cmt(0, 5'd6, 32'h60, 4'd1); tick();
        rd(0, 5'd6); #1;
        expect_src("x6_no_clear", 0, 1'b0, 4'd2, 32'd0);
        cmt(1, 5'd6, 32'h61, 4'd2); #1;
        expect_src("x6_fwd1", 0, 1'b1, 4'd0, 32'h61);
        tick();
        rd(0, 5'd6); #1;
        expect_src("x6_stored", 0, 1'b1, 4'd0, 32'h61);

        // rdy low holds state
        rdy = 1'b0; ren(0, 5'd11, 4'd3); cmt(0, 5'd5, 32'hBEEF, 4'd0); tick();
        rd(0, 5'd11); rd(1, 5'd5); #1;
        expect_src("hold_x11", 0, 1'b1, 4'd0, 32'd0);
        expect_src("hold_x5", 1, 1'b1, 4'd0, 32'hDEAD);

        // Reset has priority over rdy=0
        ren(0, 5'd12, 4'd4); tick();
        rst = 1'b1; rdy = 1'b0; jump_flag = 1'b1; tick();
        rd(0, 5'd12); rd(1, 5'd5); #1;
        expect_src("rst_x12", 0, 1'b1, 4'd0, 32'd0);
        expect_src("rst_x5b", 1, 1'b1, 4'd0, 32'd0);

        // x0 is never written, renamed or bypassed
        ren(0, 5'd0, 4'd5); rd(2, 5'd0); #1;
        expect_src("x0_nobyp", 2, 1'b1, 4'd0, 32'd0);
        cmt(0, 5'd0, 32'h99, 4'd0); tick();
        rd(0, 5'd0); #1;
        expect_src("x0_read", 0, 1'b1, 4'd0, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
